// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues in-order memory reads for incoming PCs and
// queues returned words with their PCs for decode; flush drops in-flight reads.
module fetch_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] OCC_FULL = (CW + 1)'(DEPTH);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    alloc_q, alloc_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic [31:0]      pc_mem_q [DEPTH];
  logic [31:0]      pc_mem_d [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [CW:0] occupancy;
  logic        issue;
  logic        req_hs;
  logic        rsp_fill;
  logic        consume;

  // pend_q counts allocated-but-unfilled entries so the full/empty ambiguity
  // of fill_q == alloc_q never has to be resolved from the pointers alone.
  always_comb begin
    occupancy = {1'b0, count_q} + {1'b0, drop_cnt_q};
    issue     = pc_valid && !flush && (occupancy < OCC_FULL);
    req_hs    = issue && imem_req_ready;
    rsp_fill  = imem_rsp_valid && !flush && (drop_cnt_q == '0) && (pend_q != '0);
    consume   = filled_q[head_q] && dec_ready && !flush;
  end

  always_comb begin
    imem_req_valid = issue;
    pc_ready       = req_hs;
    imem_req_addr  = {pc_in[31:2], 2'b00};
    dec_valid      = filled_q[head_q];
    dec_instr      = instr_mem_q[head_q];
    dec_pc         = pc_mem_q[head_q];
  end

  always_comb begin
    head_d      = head_q;
    alloc_d     = alloc_q;
    fill_d      = fill_q;
    count_d     = count_q;
    drop_cnt_d  = drop_cnt_q;
    pend_d      = pend_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    filled_d    = filled_q;

    if (flush) begin
      head_d     = '0;
      alloc_d    = '0;
      fill_d     = '0;
      count_d    = '0;
      pend_d     = '0;
      filled_d   = '0;
      // Unfilled entries become drops; a response this cycle is one of them.
      drop_cnt_d = drop_cnt_q + pend_q
                   - CW'(imem_rsp_valid && ((drop_cnt_q != '0) || (pend_q != '0)));
    end else begin
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end

      if (rsp_fill) begin
        instr_mem_d[fill_q] = imem_rsp_data;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + PW'(1);
      end

      if (consume) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end

      if (req_hs) begin
        pc_mem_d[alloc_q] = pc_in;
        alloc_d           = alloc_q + PW'(1);
      end

      count_d = count_q + CW'(req_hs) - CW'(consume);
      pend_d  = pend_q + CW'(req_hs) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      pend_q     <= '0;
      filled_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      alloc_q     <= alloc_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      pend_q      <= pend_d;
      filled_q    <= filled_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule
